// File: rtl/render_unit.sv
// render_unit: memory-mapped fill / line / sprite rasteriser.
// The CPU programs coordinates, geometry, texture base and texture code over an
// Avalon-MM slave, then writes the trigger register. The unit then fills the
// screen, draws the centre divider column, or blits a texture from an external
// ROM (1-cycle read latency) into a column-major frame buffer (addr = x*FB_H+y).
//
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   slave_*            Avalon-MM register interface (waitrequest = busy)
//   tex_addr, tex_q    texture ROM address / texel {opaque, RRGGBB}
//   fb_addr, fb_data   frame-buffer write address and colour
//   fb_wren            frame-buffer write enable
module render_unit #(
   parameter int unsigned FB_W   = 320,
   parameter int unsigned FB_H   = 240,
   parameter int unsigned TEX_AW = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        slave_address,
   input  logic              slave_read,
   output logic [31:0]       slave_readdata,
   input  logic              slave_write,
   input  logic [31:0]       slave_writedata,
   output logic              slave_waitrequest,
   output logic [TEX_AW-1:0] tex_addr,
   input  logic [6:0]        tex_q,
   output logic [16:0]       fb_addr,
   output logic [5:0]        fb_data,
   output logic              fb_wren
);

   localparam logic [16:0] LastPix   = 17'(FB_W * FB_H - 1);
   localparam logic [16:0] LineFirst = 17'((FB_W / 2 - 1) * FB_H);
   localparam logic [16:0] LineLast  = 17'((FB_W / 2) * FB_H - 1);
   localparam logic [6:0]  LineCode  = 7'h1F;

   typedef enum logic [2:0] {
      StIdle, StFill, StLine, StSprInit, StSprScan, StSprDrain
   } state_e;

   state_e state_q, state_d;

   // Programmable registers
   logic [10:0]       mid_x_q, mid_x_d;
   logic [10:0]       mid_y_q, mid_y_d;
   logic              neg_q, neg_d;
   logic [6:0]        tex_code_q, tex_code_d;
   logic [8:0]        width_q, width_d;
   logic [7:0]        height_q, height_d;
   logic [TEX_AW-1:0] base_q, base_d;

   // Fill / line output registers
   logic [16:0]       laddr_q, laddr_d;
   logic [5:0]        ldata_q, ldata_d;
   logic              lwren_q, lwren_d;

   // Sprite scan state
   logic [10:0]       x0_q, x0_d;
   logic [10:0]       y0_q, y0_d;
   logic [8:0]        col_q, col_d;
   logic [7:0]        row_q, row_d;
   logic [TEX_AW-1:0] tex_addr_q, tex_addr_d;
   // Pixel pipeline: fetch address issued this cycle, texel arrives next cycle
   logic              pv_q, pv_d;
   logic [16:0]       pa_q, pa_d;

   logic        plotting;
   logic        trigger;
   logic [10:0] wd_coord;
   logic [10:0] cur_x, cur_y, x_mul;
   logic        x_on, y_on;
   logic [16:0] pix_addr;
   logic        unused_wd;

   assign unused_wd = ^slave_writedata[31:17];

   assign plotting          = (state_q != StIdle);
   assign slave_waitrequest = plotting;
   assign trigger           = slave_write && !plotting && (slave_address == 4'd6);
   assign wd_coord          = neg_q ? (~slave_writedata[10:0] + 11'd1) : slave_writedata[10:0];

   assign cur_x    = x0_q + {2'b00, col_q};
   assign cur_y    = y0_q + {3'b000, row_q};
   assign x_on     = !cur_x[10] && (cur_x < 11'(FB_W));
   assign y_on     = !cur_y[10] && (cur_y < 11'(FB_H));
   assign x_mul    = x_on ? cur_x : 11'd0;
   assign pix_addr = 17'(x_mul) * 17'(FB_H) + 17'(cur_y);

   // Sprite pixels are written the cycle their texel returns from the ROM
   assign tex_addr = tex_addr_q;
   assign fb_wren  = lwren_q | (pv_q & tex_q[6]);
   assign fb_addr  = pv_q ? pa_q : laddr_q;
   assign fb_data  = pv_q ? tex_q[5:0] : ldata_q;

   always_comb begin
      slave_readdata = 32'd0;
      if (slave_read) begin
         unique case (slave_address)
            4'd1:    slave_readdata = {{21{mid_x_q[10]}}, mid_x_q};
            4'd2:    slave_readdata = {{21{mid_y_q[10]}}, mid_y_q};
            4'd3:    slave_readdata = {31'd0, neg_q};
            4'd4:    slave_readdata = {25'd0, tex_code_q};
            4'd5:    slave_readdata = {15'd0, height_q, width_q};
            4'd7:    slave_readdata = 32'(base_q);
            default: slave_readdata = 32'd0;
         endcase
      end
   end

   always_comb begin
      state_d    = state_q;
      mid_x_d    = mid_x_q;
      mid_y_d    = mid_y_q;
      neg_d      = neg_q;
      tex_code_d = tex_code_q;
      width_d    = width_q;
      height_d   = height_q;
      base_d     = base_q;
      laddr_d    = laddr_q;
      ldata_d    = ldata_q;
      lwren_d    = lwren_q;
      x0_d       = x0_q;
      y0_d       = y0_q;
      col_d      = col_q;
      row_d      = row_q;
      tex_addr_d = tex_addr_q;
      pv_d       = 1'b0;
      pa_d       = 17'd0;

      if (slave_write && !plotting) begin
         unique case (slave_address)
            4'd1:    mid_x_d    = wd_coord;
            4'd2:    mid_y_d    = wd_coord;
            4'd3:    neg_d      = slave_writedata[0];
            4'd4:    tex_code_d = slave_writedata[6:0];
            4'd5: begin
               width_d  = slave_writedata[8:0];
               height_d = slave_writedata[16:9];
            end
            4'd7:    base_d     = slave_writedata[TEX_AW-1:0];
            default: ;
         endcase
      end

      unique case (state_q)
         StIdle: begin
            if (trigger) begin
               if (tex_code_q[6])               state_d = StFill;
               else if (tex_code_q == LineCode) state_d = StLine;
               else                             state_d = StSprInit;
            end
         end
         // lwren_q low marks the setup cycle before the first write
         StFill: begin
            if (!lwren_q) begin
               lwren_d = 1'b1;
               laddr_d = 17'd0;
               ldata_d = tex_code_q[5:0];
            end else if (laddr_q == LastPix) begin
               lwren_d = 1'b0;
               laddr_d = 17'd0;
               ldata_d = 6'd0;
               state_d = StIdle;
            end else begin
               laddr_d = laddr_q + 17'd1;
            end
         end
         StLine: begin
            if (!lwren_q) begin
               lwren_d = 1'b1;
               laddr_d = LineFirst;
               ldata_d = 6'd0;
            end else if (laddr_q == LineLast) begin
               lwren_d = 1'b0;
               laddr_d = 17'd0;
               state_d = StIdle;
            end else begin
               laddr_d = laddr_q + 17'd1;
            end
         end
         StSprInit: begin
            x0_d       = mid_x_q - {3'b000, width_q[8:1]};
            y0_d       = mid_y_q - {4'b0000, height_q[7:1]};
            tex_addr_d = base_q;
            col_d      = 9'd0;
            row_d      = 8'd0;
            state_d    = (width_q == 9'd0 || height_q == 8'd0) ? StIdle : StSprScan;
         end
         StSprScan: begin
            pv_d       = x_on && y_on;
            pa_d       = pix_addr;
            tex_addr_d = tex_addr_q + TEX_AW'(1);
            if (row_q == height_q - 8'd1) begin
               row_d = 8'd0;
               if (col_q == width_q - 9'd1) state_d = StSprDrain;
               else                         col_d   = col_q + 9'd1;
            end else begin
               row_d = row_q + 8'd1;
            end
         end
         StSprDrain: state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         mid_x_q    <= '0;
         mid_y_q    <= '0;
         neg_q      <= 1'b0;
         tex_code_q <= '0;
         width_q    <= '0;
         height_q   <= '0;
         base_q     <= '0;
         laddr_q    <= '0;
         ldata_q    <= '0;
         lwren_q    <= 1'b0;
         x0_q       <= '0;
         y0_q       <= '0;
         col_q      <= '0;
         row_q      <= '0;
         tex_addr_q <= '0;
         pv_q       <= 1'b0;
         pa_q       <= '0;
      end else begin
         state_q    <= state_d;
         mid_x_q    <= mid_x_d;
         mid_y_q    <= mid_y_d;
         neg_q      <= neg_d;
         tex_code_q <= tex_code_d;
         width_q    <= width_d;
         height_q   <= height_d;
         base_q     <= base_d;
         laddr_q    <= laddr_d;
         ldata_q    <= ldata_d;
         lwren_q    <= lwren_d;
         x0_q       <= x0_d;
         y0_q       <= y0_d;
         col_q      <= col_d;
         row_q      <= row_d;
         tex_addr_q <= tex_addr_d;
         pv_q       <= pv_d;
         pa_q       <= pa_d;
      end
   end

endmodule

// File: tb/tb_render_unit.sv
// tb_render_unit: directed bench for render_unit. A synchronous ROM model
// feeds texels; each operation is compared write-by-write against a
// reference list of expected frame-buffer writes built by the bench.
module tb_render_unit;

   logic        clk;
   logic        rst;
   logic [3:0]  slave_address;
   logic        slave_read;
   logic [31:0] slave_readdata;
   logic        slave_write;
   logic [31:0] slave_writedata;
   logic        slave_waitrequest;
   logic [15:0] tex_addr;
   logic [6:0]  tex_q;
   logic [16:0] fb_addr;
   logic [5:0]  fb_data;
   logic        fb_wren;

   int n_total;
   int n_bad;
   int exp_a[$];
   int exp_d[$];
   int tex0;
   int rd;
   logic [6:0] rom_val;
   logic       rom_pat;

   render_unit #(
      .FB_W   (320),
      .FB_H   (240),
      .TEX_AW (16)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .slave_address     (slave_address),
      .slave_read        (slave_read),
      .slave_readdata    (slave_readdata),
      .slave_write       (slave_write),
      .slave_writedata   (slave_writedata),
      .slave_waitrequest (slave_waitrequest),
      .tex_addr          (tex_addr),
      .tex_q             (tex_q),
      .fb_addr           (fb_addr),
      .fb_data           (fb_data),
      .fb_wren           (fb_wren)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Pattern ROM: opaque unless addr[1:0]==0, colour = addr[7:2]
   function automatic logic [6:0] texel(input logic [15:0] a);
      if (rom_pat) return {(a[1:0] != 2'd0), a[7:2]};
      return rom_val;
   endfunction

   always_ff @(posedge clk) tex_q <= texel(tex_addr);

   task automatic check(input string tag, input int got, input int exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      slave_address   = a;
      slave_writedata = d;
      slave_write     = 1'b1;
      @(negedge clk);
      slave_write     = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a, output int d);
      @(negedge clk);
      slave_address = a;
      slave_read    = 1'b1;
      #1;
      d = int'(slave_readdata);
      slave_read = 1'b0;
   endtask

   task automatic build_sprite(input int mx, input int my, input int w, input int h,
                               input int base);
      int x0, y0, x, y;
      logic [15:0] a;
      logic [6:0]  t;
      exp_a.delete();
      exp_d.delete();
      x0 = mx - (w / 2);
      y0 = my - (h / 2);
      for (int c = 0; c < w; c++) begin
         for (int r = 0; r < h; r++) begin
            a = 16'(base + c * h + r);
            t = texel(a);
            x = x0 + c;
            y = y0 + r;
            if (t[6] && x >= 0 && x < 320 && y >= 0 && y < 240) begin
               exp_a.push_back(x * 240 + y);
               exp_d.push_back(int'(t[5:0]));
            end
         end
      end
   endtask

   task automatic build_range(input int first, input int last, input int colour);
      exp_a.delete();
      exp_d.delete();
      for (int i = first; i <= last; i++) begin
         exp_a.push_back(i);
         exp_d.push_back(colour);
      end
   endtask

   // Entered on the first busy cycle; follows the operation until waitrequest drops
   task automatic run_op(input string tag, input int exp_cycles, input int first_a,
                         input int first_d);
      int cyc, nwr, bad_seq, fa, fd;
      cyc = 0; nwr = 0; bad_seq = 0; fa = -1; fd = -1;
      while (slave_waitrequest === 1'b1 && cyc < 90000) begin
         if (cyc == 1) tex0 = int'(tex_addr);
         if (fb_wren === 1'b1) begin
            if (nwr == 0) begin
               fa = int'(fb_addr);
               fd = int'(fb_data);
            end
            if (nwr >= exp_a.size()) bad_seq++;
            else if (int'(fb_addr) != exp_a[nwr] || int'(fb_data) != exp_d[nwr]) bad_seq++;
            nwr++;
         end
         cyc++;
         @(negedge clk);
      end
      check({tag, "_cycles"}, cyc, exp_cycles);
      check({tag, "_nwrites"}, nwr, exp_a.size());
      check({tag, "_seq_errs"}, bad_seq, 0);
      if (first_a >= 0) begin
         check({tag, "_first_addr"}, fa, first_a);
         check({tag, "_first_data"}, fd, first_d);
      end
      check({tag, "_end_wren"}, int'(fb_wren), 0);
      check({tag, "_end_addr"}, int'(fb_addr), 0);
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      rom_val = 7'h40;
      rom_pat = 1'b0;
      slave_address = '0; slave_read = 1'b0; slave_write = 1'b0; slave_writedata = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_wren", int'(fb_wren), 0);
      check("rst_fbaddr", int'(fb_addr), 0);
      check("rst_fbdata", int'(fb_data), 0);
      check("rst_texaddr", int'(tex_addr), 0);
      check("rst_wait", int'(slave_waitrequest), 0);
      rst = 1'b0;
      bus_read(4'd4, rd);
      check("rst_texcode", rd, 0);

      // Sprite 18x13 at (20,20), base 0
      bus_write(4'd1, 32'd20);
      bus_write(4'd2, 32'd20);
      bus_write(4'd5, (32'd13 << 9) | 32'd18);
      bus_write(4'd7, 32'd0);
      bus_write(4'd4, 32'h05);
      bus_read(4'd1, rd);
      check("rd_midx", rd, 20);
      bus_read(4'd5, rd);
      check("rd_geom", rd, (13 << 9) | 18);
      build_sprite(20, 20, 18, 13, 0);
      bus_write(4'd6, 32'd1);
      run_op("spr", 2 + 234, 11 * 240 + 14, 0);

      // Zero width: init cycle only
      bus_write(4'd5, (32'd5 << 9));
      build_sprite(20, 20, 0, 5, 0);
      bus_write(4'd6, 32'd1);
      run_op("zero", 1, -1, -1);

      // Negative coordinates
      bus_write(4'd3, 32'd1);
      bus_write(4'd1, 32'd1);
      bus_write(4'd2, 32'd1);
      bus_read(4'd1, rd);
      check("rd_negx", rd, -1);
      bus_read(4'd2, rd);
      check("rd_negy", rd, -1);
      bus_read(4'd0, rd);
      check("rd_reg0", rd, 0);
      bus_read(4'd6, rd);
      check("rd_reg6", rd, 0);
      bus_write(4'd3, 32'd0);
      bus_write(4'd5, (32'd180 << 9) | 32'd16);
      bus_write(4'd7, 32'd2880);
      build_sprite(-1, -1, 16, 180, 2880);
      bus_write(4'd6, 32'd1);
      run_op("neg", 2 + 2880, 0, 0);
      check("neg_tex0", tex0, 2880);

      // Clipping at bottom edge
      rom_val = 7'h7F;
      bus_write(4'd1, 32'd159);
      bus_write(4'd2, 32'd239);
      bus_write(4'd5, (32'd24 << 9) | 32'd24);
      bus_write(4'd7, 32'd5184);
      build_sprite(159, 239, 24, 24, 5184);
      bus_write(4'd6, 32'd1);
      run_op("clip", 2 + 576, 147 * 240 + 227, 8'h3F);
      check("clip_tex0", tex0, 5184);

      // Address-dependent texels, some transparent
      rom_pat = 1'b1;
      bus_write(4'd1, 32'd100);
      bus_write(4'd2, 32'd50);
      bus_write(4'd5, (32'd3 << 9) | 32'd5);
      bus_write(4'd7, 32'd100);
      build_sprite(100, 50, 5, 3, 100);
      bus_write(4'd6, 32'd1);
      run_op("pat", 2 + 15, 98 * 240 + 50, 25);
      rom_pat = 1'b0;

      // Divider line
      bus_write(4'd4, 32'h1F);
      build_range(38160, 38399, 0);
      bus_write(4'd6, 32'd1);
      run_op("line", 241, 38160, 0);

      // Full-screen fill
      bus_write(4'd4, 32'h7C);
      build_range(0, 76799, 8'h3C);
      bus_write(4'd6, 32'd1);
      check("fill_wait", int'(slave_waitrequest), 1);
      run_op("fill", 76801, 0, 8'h3C);

      // Reset in the middle of a fill
      bus_write(4'd6, 32'd1);
      repeat (50) @(negedge clk);
      check("mid_wren", int'(fb_wren), 1);
      #2 rst = 1'b1;
      #1;
      check("abort_wait", int'(slave_waitrequest), 0);
      check("abort_wren", int'(fb_wren), 0);
      check("abort_addr", int'(fb_addr), 0);
      @(negedge clk);
      rst = 1'b0;
      bus_read(4'd4, rd);
      check("abort_texcode", rd, 0);
      bus_write(4'd4, 32'h1F);
      build_range(38160, 38399, 0);
      bus_write(4'd6, 32'd1);
      run_op("line2", 241, 38160, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
